// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the single write port of the register file between the ALU
//   result path and the load result path. Arbitration is round-robin and
//   uses valid/ready handshakes. The winning request is registered for one
//   cycle before it drives the register-file write port. A pending-write
//   mask is exported so that issue logic can stall on RAW hazards.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   alu_valid/waddr/wdata/ready  ALU write-back request channel
//   mem_valid/waddr/wdata/ready  load write-back request channel
//   flush                        kills the ALU request presented this cycle
//   rf_en/rf_waddr/rf_wdata      registered register-file write port
//   busy_mask                    one bit per register with a write in flight
//   last_grant                   round-robin pointer (0 = ALU, 1 = MEM)
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [AW-1:0]     alu_waddr,
    input  logic [DW-1:0]     alu_wdata,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [AW-1:0]     mem_waddr,
    input  logic [DW-1:0]     mem_wdata,
    output logic              mem_ready,
    input  logic              flush,
    output logic              rf_en,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic [(2**AW)-1:0] busy_mask,
    output logic              last_grant
);

    logic alu_req;
    logic grant_alu;
    logic grant_mem;

    // A flushed ALU request is treated as if it were not there at all, so it
    // neither wins arbitration nor blocks the load path.
    always_comb begin
        alu_req   = alu_valid && !flush;
        grant_alu = rst_n && alu_req && (!mem_valid || last_grant);
        grant_mem = rst_n && mem_valid && (!alu_req || !last_grant);
        alu_ready = grant_alu;
        mem_ready = grant_mem;
    end

    // The register file never back-pressures, so the output stage simply
    // captures the winner every cycle. Writes to x0 complete the handshake
    // and move the pointer, but never raise rf_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_en      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            last_grant <= 1'b1;
        end else if (grant_alu) begin
            rf_en      <= (alu_waddr != '0);
            rf_waddr   <= alu_waddr;
            rf_wdata   <= alu_wdata;
            last_grant <= 1'b0;
        end else if (grant_mem) begin
            rf_en      <= (mem_waddr != '0);
            rf_waddr   <= mem_waddr;
            rf_wdata   <= mem_wdata;
            last_grant <= 1'b1;
        end else begin
            rf_en      <= 1'b0;
        end
    end

    // Live requests are included whether or not they win this cycle, and the
    // output stage covers the write that has not reached the array yet.
    // Not gated by reset: during reset the mask still reflects live valids.
    always_comb begin
        busy_mask = '0;
        if (alu_req) begin
            busy_mask[alu_waddr] = 1'b1;
        end
        if (mem_valid) begin
            busy_mask[mem_waddr] = 1'b1;
        end
        if (rf_en) begin
            busy_mask[rf_waddr] = 1'b1;
        end
        busy_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_waddr = '0;
    logic [DW-1:0] alu_wdata = '0;
    logic          alu_ready;
    logic          mem_valid = 1'b0;
    logic [AW-1:0] mem_waddr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          mem_ready;
    logic          flush = 1'b0;
    logic          rf_en;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [31:0]   busy_mask;
    logic          last_grant;

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .flush(flush),
        .rf_en(rf_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_mask(busy_mask), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    // Register file driven by the DUT write port (not reset, like the real array).
    logic [31:0] tb_rf [32];
    always @(posedge clk) begin
        if (rf_en) tb_rf[rf_waddr] <= rf_wdata;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference model: pointer, pending output-stage write, expected array contents.
    logic        m_last;
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] mrf [32];
    int          exp_pulses;
    int          dut_pulses;

    task automatic do_reset();
        rst_n = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_last = 1'b1;
        m_en = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // One cycle against the model: decide the winner from the arbitration
    // rules, check the combinational outputs, then the registered ones.
    task automatic model_step(input string tag, output logic acc_a, output logic acc_m);
        int          win;
        logic        a, m;
        logic [4:0]  aa, ma;
        logic [31:0] ad, md, eb;
        @(negedge clk);
        a = alu_valid && !flush;
        m = mem_valid;
        aa = alu_waddr; ma = mem_waddr; ad = alu_wdata; md = mem_wdata;
        if (a && m)  win = m_last ? 1 : 2;
        else if (a)  win = 1;
        else if (m)  win = 2;
        else         win = 0;
        eb = '0;
        if (a) eb[aa] = 1'b1;
        if (m) eb[ma] = 1'b1;
        if (m_en) eb[m_addr] = 1'b1;
        eb[0] = 1'b0;
        chk({tag, "_alu_ready"}, alu_ready, win == 1);
        chk({tag, "_mem_ready"}, mem_ready, win == 2);
        chk({tag, "_busy"}, busy_mask, eb);
        @(posedge clk);
        #1;
        acc_a = (win == 1);
        acc_m = (win == 2);
        if (win != 0) begin
            m_addr = (win == 1) ? aa : ma;
            m_data = (win == 1) ? ad : md;
            m_en   = (m_addr != 0);
            m_last = (win == 2);
            if (m_en) begin
                mrf[m_addr] = m_data;
                exp_pulses++;
            end
        end else begin
            m_en = 1'b0;
        end
        if (rf_en) dut_pulses++;
        chk({tag, "_rf_en"}, rf_en, m_en);
        chk({tag, "_rf_waddr"}, rf_waddr, m_addr);
        chk({tag, "_rf_wdata"}, rf_wdata, m_data);
        chk({tag, "_last_grant"}, last_grant, m_last);
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        fl;
        logic        e_ar;
        logic        e_mr;
        logic [31:0] e_busy;
        logic        e_en;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_last;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic acc_a, acc_m;
        int   bad;

        for (int i = 0; i < 32; i++) begin
            tb_rf[i] = '0;
            mrf[i] = '0;
        end
        exp_pulses = 0;
        dut_pulses = 0;

        //        av aa  ad            mv ma md      fl  ar mr busy     en addr data          last
        tbl[0]  = '{1, 5, 32'hA,        1, 6, 32'hB,  0,  1, 0, 32'h60,  1, 5, 32'hA,        0};
        tbl[1]  = '{1, 5, 32'hA,        1, 6, 32'hB,  0,  0, 1, 32'h60,  1, 6, 32'hB,        1};
        tbl[2]  = tbl[0];
        tbl[3]  = tbl[1];
        tbl[4]  = tbl[0];
        tbl[5]  = tbl[1];
        tbl[6]  = '{1, 5, 32'hA,        1, 6, 32'hB,  1,  0, 1, 32'h40,  1, 6, 32'hB,        1};
        tbl[7]  = '{1, 5, 32'hA,        1, 6, 32'hB,  0,  1, 0, 32'h60,  1, 5, 32'hA,        0};
        tbl[8]  = '{0, 0, 32'h0,        0, 0, 32'h0,  0,  0, 0, 32'h20,  0, 5, 32'hA,        0};
        tbl[9]  = '{1, 0, 32'hDEADBEEF, 0, 0, 32'h0,  0,  1, 0, 32'h0,   0, 0, 32'hDEADBEEF, 0};
        tbl[10] = '{0, 0, 32'h0,        0, 0, 32'h0,  0,  0, 0, 32'h0,   0, 0, 32'hDEADBEEF, 0};
        tbl[11] = '{0, 0, 32'h0,        1, 9, 32'h99, 0,  0, 1, 32'h200, 1, 9, 32'h99,       1};
        tbl[12] = '{1, 3, 32'h33,       0, 0, 32'h0,  1,  0, 0, 32'h200, 0, 9, 32'h99,       1};
        tbl[13] = '{0, 0, 32'h0,        0, 0, 32'h0,  0,  0, 0, 32'h0,   0, 9, 32'h99,       1};

        // Reset held with both sources requesting.
        alu_valid = 1'b1; alu_waddr = 5; alu_wdata = 32'hA;
        mem_valid = 1'b1; mem_waddr = 6; mem_wdata = 32'hB;
        #12;
        chk("rst_rf_en", rf_en, 1'b0);
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_mem_ready", mem_ready, 1'b0);
        chk("rst_busy", busy_mask, 32'h60);
        chk("rst_last_grant", last_grant, 1'b1);
        chk("rst_rf_waddr", rf_waddr, 5'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Alternation, flush, x0 drop, flushed lone ALU request.
        for (int i = 0; i < 14; i++) begin
            alu_valid = tbl[i].av; alu_waddr = tbl[i].aa; alu_wdata = tbl[i].ad;
            mem_valid = tbl[i].mv; mem_waddr = tbl[i].ma; mem_wdata = tbl[i].md;
            flush = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("t%0d_alu_ready", i), alu_ready, tbl[i].e_ar);
            chk($sformatf("t%0d_mem_ready", i), mem_ready, tbl[i].e_mr);
            chk($sformatf("t%0d_busy", i), busy_mask, tbl[i].e_busy);
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_rf_en", i), rf_en, tbl[i].e_en);
            chk($sformatf("t%0d_rf_waddr", i), rf_waddr, tbl[i].e_addr);
            chk($sformatf("t%0d_rf_wdata", i), rf_wdata, tbl[i].e_data);
            chk($sformatf("t%0d_last_grant", i), last_grant, tbl[i].e_last);
        end

        // Same-address collision: ALU first after reset, MEM later and wins.
        do_reset();
        alu_valid = 1'b1; alu_waddr = 7; alu_wdata = 32'h11;
        mem_valid = 1'b1; mem_waddr = 7; mem_wdata = 32'h22;
        @(negedge clk);
        chk("col1_alu_ready", alu_ready, 1'b1);
        chk("col1_mem_ready", mem_ready, 1'b0);
        chk("col1_busy7", busy_mask[7], 1'b1);
        @(posedge clk);
        #1;
        chk("col1_rf_en", rf_en, 1'b1);
        chk("col1_rf_wdata", rf_wdata, 32'h11);
        alu_valid = 1'b0;
        @(negedge clk);
        chk("col2_mem_ready", mem_ready, 1'b1);
        chk("col2_busy7", busy_mask[7], 1'b1);
        @(posedge clk);
        #1;
        chk("col2_rf_en", rf_en, 1'b1);
        chk("col2_rf_wdata", rf_wdata, 32'h22);
        mem_valid = 1'b0;
        @(negedge clk);
        chk("col3_busy7", busy_mask[7], 1'b1);
        @(posedge clk);
        #1;
        chk("col3_rf_en", rf_en, 1'b0);
        @(negedge clk);
        chk("col4_busy7", busy_mask[7], 1'b0);
        chk("col4_x7", tb_rf[7], 32'h22);

        // Randomized traffic with held requests, flushes and collisions.
        do_reset();
        for (int i = 0; i < 32; i++) mrf[i] = tb_rf[i];
        exp_pulses = 0;
        dut_pulses = 0;
        acc_a = 1'b1;
        acc_m = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (!alu_valid || acc_a) begin
                alu_valid = ($urandom_range(0, 99) < 65);
                alu_waddr = 5'($urandom_range(0, 7));
                alu_wdata = $urandom;
            end
            if (!mem_valid || acc_m) begin
                mem_valid = ($urandom_range(0, 99) < 65);
                mem_waddr = 5'($urandom_range(0, 7));
                mem_wdata = $urandom;
            end
            flush = ($urandom_range(0, 9) == 0);
            model_step("rand", acc_a, acc_m);
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        flush = 1'b0;
        model_step("drain", acc_a, acc_m);
        model_step("drain", acc_a, acc_m);
        chk("rand_write_pulses", dut_pulses, exp_pulses);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (tb_rf[i] !== mrf[i]) bad++;
        end
        chk("rand_rf_contents_bad", bad, 0);

        // Reset while a write sits in the output stage: the write is lost.
        alu_valid = 1'b1; alu_waddr = 12; alu_wdata = 32'h55;
        @(posedge clk);
        #1;
        chk("mid_rf_en_before", rf_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rf_en", rf_en, 1'b0);
        chk("mid_rf_waddr", rf_waddr, 5'd0);
        chk("mid_rf_wdata", rf_wdata, 32'd0);
        chk("mid_last_grant", last_grant, 1'b1);
        chk("mid_alu_ready", alu_ready, 1'b0);
        chk("mid_busy", busy_mask, 32'h1000);
        @(posedge clk);
        #1;
        chk("mid_rf_en_held", rf_en, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_alu_ready_after", alu_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("mid_rf_en_after", rf_en, 1'b1);
        chk("mid_rf_waddr_after", rf_waddr, 5'd12);
        alu_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
